// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore serial sequence detector with run-time overlap control
// and a saturating, clearable match counter.
//
// state | meaning
// S0    | no pattern prefix matched
// Sk    | the last k accepted bits equal PATTERN's first k bits (k maximal)
// S_N   | full match (k = PAT_LEN), Y = 1
module seq_detect_moore_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         X,
    input  logic                         overlap,
    input  logic                         clr_cnt,
    output logic                         Y,
    output logic [$clog2(PAT_LEN+1)-1:0] state,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int               SW       = $clog2(PAT_LEN + 1);
    localparam int               NS       = 2 ** SW;
    localparam logic [SW-1:0]    FULL     = SW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SW-1:0]    state_q, state_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [SW-1:0]    nxt0 [NS];
    logic [SW-1:0]    nxt1 [NS];

    // The history behind Sk is exactly PATTERN's first k bits, so the next
    // state is the longest border of (prefix_k, x) that is also a prefix.
    function automatic logic [SW-1:0] calc_next(input int k, input logic x);
        logic [SW-1:0]      best;
        logic               ok;
        logic               sb;
        logic [PAT_LEN-1:0] sh_s;
        logic [PAT_LEN-1:0] sh_p;
        int                 pos;
        best = '0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    pos  = k + 1 - j + i;
                    sh_s = PATTERN >> ((pos < k) ? (PAT_LEN - 1 - pos) : 0);
                    sb   = (pos < k) ? sh_s[0] : x;
                    sh_p = PATTERN >> (PAT_LEN - 1 - i);
                    if (sb != sh_p[0]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = SW'(j);
                end
            end
        end
        return best;
    endfunction

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            nxt0[k] = (k <= PAT_LEN) ? calc_next(k, 1'b0) : '0;
            nxt1[k] = (k <= PAT_LEN) ? calc_next(k, 1'b1) : '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        if (en) begin
            if (state_q == FULL && !overlap) begin
                state_d = X ? nxt1[0] : nxt0[0];
            end else begin
                state_d = X ? nxt1[state_q] : nxt0[state_q];
            end
            if (state_d == FULL && match_cnt_q != CNT_MAX) begin
                match_cnt_d = match_cnt_q + CNT_W'(1);
            end
        end
        if (clr_cnt) begin
            match_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign state     = state_q;
    assign Y         = (state_q == FULL);
    assign match_cnt = match_cnt_q;

endmodule

// File: doc/seq_detect_moore_param.md
# seq_detect_moore_param

Parametrised Moore-type serial sequence detector: the next generation of the team's fixed-pattern Moore detector. It watches a 1-bit serial stream and raises a registered match flag one cycle after the final pattern bit is sampled. Pattern, length and counter width are compile-time parameters; overlap mode and input qualification are run-time controls. A saturating match counter is included. It sits in the serial-protocol front end, after the bit synchroniser and ahead of frame alignment logic.

## Interface

Parameters:
- PAT_LEN, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101: PAT_LEN-bit pattern; PATTERN[PAT_LEN-1] is the first bit expected on the stream.
- CNT_W, 8: width of the match counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  bit qualifier; X is sampled only on edges where en=1.
- X  input  1  serial data bit.
- overlap  input  1  1 = overlapping matches allowed; 0 = search restarts after each match.
- clr_cnt  input  1  synchronous clear of match_cnt.
- Y  output  1  Moore match flag; 1 exactly when state = PAT_LEN.
- state  output  $clog2(PAT_LEN+1)  current state = number of pattern bits currently matched.
- match_cnt  output  CNT_W  number of matches since reset or clear; saturates.

## Operation

- States S0..S_PAT_LEN; Sk means the most recent k accepted bits equal the first k pattern bits, with k the largest such value.
- Y is decoded from state only (Moore): Y = (state == PAT_LEN). It never depends combinationally on X, en or overlap.
- On an edge with en=1, the next state is the largest j (0..PAT_LEN) such that the last j accepted bits, including the new X, equal PATTERN's first j bits:
  - from Sk with k<PAT_LEN, all accepted history is considered;
  - from S_PAT_LEN with overlap=1, the matched bits remain history, so a match can share a prefix with the previous match;
  - from S_PAT_LEN with overlap=0, history is discarded and the next state is computed from the new X alone, as if from S0.
- On an edge with en=0, state, Y and history hold. The X value is ignored.
- overlap is sampled on each en=1 edge. Changing it mid-stream affects only the transition out of S_PAT_LEN.
- match_cnt increments by 1 on each edge where the next state is S_PAT_LEN and en=1. It holds at 2^CNT_W−1 once reached.
- clr_cnt=1 sets match_cnt to 0 on that edge. If clr_cnt coincides with a match-completing edge, match_cnt becomes 0, the clear wins, and state/Y still update normally.
- Reset values: state=0, Y=0, match_cnt=0, history cleared. rst dominates en and clr_cnt.
- A reset asserted mid-sequence discards every partial match.

## Timing

- Latency: Y rises in the cycle following the edge that samples the last pattern bit, so it is visible one clock after that bit is presented.
- Y stays high until the next en=1 edge; it stays high longer only if that edge completes another match (self-overlapping pattern, overlap=1).
- With en held low after a match, Y stays high indefinitely.
- match_cnt updates on the same edge on which Y rises.
- Reset takes effect on the first rising edge with rst=1; the first bit is accepted on the first edge with rst=0 and en=1.

## Test plan

- Defaults, overlap=1, en=1: after reset, X = 1,1,0,1 on consecutive edges -> state goes 1,2,3,4; Y=1 for exactly one cycle after the 4th edge; match_cnt=1.
- Defaults, stream 1,1,0,1,1,0,1:
  - overlap=1 -> Y pulses after bits 4 and 7; match_cnt=2;
  - overlap=0 -> a single pulse after bit 4; state after bit 7 = 1; match_cnt=1.
- Gaps: X = 1,1, then en=0 for 3 cycles with X toggling, then en=1 with X = 0,1 -> match after the final bit; state holds at 2 during the gap.
- Reset mid-sequence: X = 1,1,0, then rst for 1 cycle, then X=1 -> state=1, Y=0, match_cnt=0.
- Self-overlap, PATTERN=4'b1111, X = six 1s:
  - overlap=1 -> Y high 3 consecutive cycles; match_cnt=3;
  - overlap=0 -> one match; final state=2; match_cnt=1.
- Saturation and clear, CNT_W=2: 5 matches -> match_cnt saturates at 3; clr_cnt together with a 6th match edge -> match_cnt=0 and Y=1.
